// File: rtl/urp_pcie_tlp_arb.sv
// ---------------------------------------------------------------------------
// urp_pcie_tlp_arb
//   Credit-gated round-robin arbiter that merges N_REQ TLP requesters onto a
//   single registered TX TLP bus.
//
// Ports
//   clk, rst        : rising-edge clock, synchronous active-high reset
//   req_valid_i     : per-requester TLP valid
//   req_data_i      : per-requester TLP, requester k at [k*DATA_W +: DATA_W]
//   req_ready_o     : per-requester accept (combinational, at most one hot)
//   tlp_data_o      : registered granted TLP
//   tlp_valid_o     : tlp_data_o holds an unsent TLP
//   tlp_ready_i     : downstream accept for tlp_data_o
//   fc_upd_valid_i  : credit return strobe
//   fc_upd_cred_i   : number of credits returned
//   credits_o       : current available credit count
//   grant_o         : one-hot owner of tlp_data_o, zero when tlp_valid_o low
//   dbg_state       : current FSM state (0 = IDLE, 1 = SEND)
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. On the requester side req_ready_o is derived combinationally
// from req_valid_i, so a requester must hold req_valid_i/req_data_i until it
// sees req_ready_o; it may drop req_valid_i at any time before that and only
// loses its turn. On the output side tlp_valid_o/tlp_data_o/grant_o stay
// stable while tlp_ready_i is low.
// ---------------------------------------------------------------------------
module urp_pcie_tlp_arb #(
    parameter int N_REQ     = 4,
    parameter int DATA_W    = 268,
    parameter int CRED_W    = 8,
    parameter int CRED_INIT = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req_valid_i,
    input  logic [N_REQ*DATA_W-1:0] req_data_i,
    output logic [N_REQ-1:0]        req_ready_o,
    output logic [DATA_W-1:0]       tlp_data_o,
    output logic                    tlp_valid_o,
    input  logic                    tlp_ready_i,
    input  logic                    fc_upd_valid_i,
    input  logic [CRED_W-1:0]       fc_upd_cred_i,
    output logic [CRED_W-1:0]       credits_o,
    output logic [N_REQ-1:0]        grant_o,
    output logic                    dbg_state
);

    localparam int LG_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t            state;
    logic [LG_W-1:0]   last_grant;

    logic              can_load;
    logic              accept;
    logic [LG_W-1:0]   start_idx;
    logic [LG_W-1:0]   cand;
    logic [LG_W-1:0]   win_idx;
    logic              win_found;
    logic [N_REQ-1:0]  win_oh;
    logic [DATA_W-1:0] win_data;
    logic [CRED_W:0]   cred_sum;
    logic [CRED_W-1:0] cred_next;

    assign dbg_state = state;

    // The output register can take a new TLP if it is empty or is being
    // drained on this same edge.
    assign can_load = !tlp_valid_o || tlp_ready_i;

    // Round-robin search starting just after the last granted requester.
    always_comb begin
        start_idx = (last_grant == LG_W'(N_REQ - 1)) ? '0 : last_grant + 1'b1;
        cand      = start_idx;
        win_idx   = '0;
        win_found = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (!win_found && req_valid_i[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
            cand = (cand == LG_W'(N_REQ - 1)) ? '0 : cand + 1'b1;
        end
    end

    always_comb begin
        win_oh   = '0;
        win_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (win_idx == LG_W'(i)) begin
                win_oh[i] = 1'b1;
                win_data  = req_data_i[i*DATA_W +: DATA_W];
            end
        end
    end

    // Credit checked against the registered count only, so a credit return
    // arriving in the same cycle cannot enable an accept until next cycle.
    assign accept = !rst && can_load && (credits_o != '0) && win_found;

    assign req_ready_o = accept ? win_oh : '0;

    // One extra bit catches overflow; accept implies credits_o >= 1, so the
    // subtraction never wraps below zero.
    always_comb begin
        cred_sum = {1'b0, credits_o}
                 - {{CRED_W{1'b0}}, accept}
                 + (fc_upd_valid_i ? {1'b0, fc_upd_cred_i} : '0);
        cred_next = cred_sum[CRED_W] ? '1 : cred_sum[CRED_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            tlp_valid_o <= 1'b0;
            tlp_data_o  <= '0;
            grant_o     <= '0;
            credits_o   <= CRED_W'(CRED_INIT);
            last_grant  <= LG_W'(N_REQ - 1);
        end else begin
            credits_o <= cred_next;
            case (state)
                IDLE: begin
                    if (accept) begin
                        tlp_data_o  <= win_data;
                        grant_o     <= win_oh;
                        last_grant  <= win_idx;
                        tlp_valid_o <= 1'b1;
                        state       <= SEND;
                    end
                end
                SEND: begin
                    if (accept) begin
                        tlp_data_o  <= win_data;
                        grant_o     <= win_oh;
                        last_grant  <= win_idx;
                        tlp_valid_o <= 1'b1;
                    end else if (tlp_ready_i) begin
                        tlp_valid_o <= 1'b0;
                        grant_o     <= '0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
